// File: rtl/dds_pkg.sv
// -----------------------------------------------------------------------------
// dds_pkg
//   Width constants shared by the DDS phase accumulator and the waveform
//   lookup stage, plus the note-command record used by note producers.
//
//   Contents:
//     DDS_PLAYER_NUM   default number of simultaneous players
//     DDS_THETA_WIDTH  phase bits handed to the lookup stage
//     DDS_ACC_WIDTH    phase accumulator width
//     DDS_FTW_WIDTH    frequency tuning word width
//     DDS_PID_WIDTH    player index width for the default player count
//     pid_width()      player index width for any player count (min 1)
//     note_cmd_t       {player, on, ftw} note command at default widths
// -----------------------------------------------------------------------------
package dds_pkg;

    localparam int DDS_PLAYER_NUM  = 3;
    localparam int DDS_THETA_WIDTH = 8;
    localparam int DDS_ACC_WIDTH   = 24;
    localparam int DDS_FTW_WIDTH   = 16;

    // A single player still needs a 1-bit index so port widths stay legal.
    function automatic int pid_width(input int players);
        return (players > 1) ? $clog2(players) : 1;
    endfunction

    localparam int DDS_PID_WIDTH = pid_width(DDS_PLAYER_NUM);

    typedef struct packed {
        logic [DDS_PID_WIDTH-1:0] player;
        logic                     on;
        logic [DDS_FTW_WIDTH-1:0] ftw;
    } note_cmd_t;

endpackage

// File: rtl/dds_phase_acc_if.sv
// -----------------------------------------------------------------------------
// dds_phase_acc_if
//   Note-command handshake between a note producer (master) and the phase
//   accumulator (slave). A command transfers on a cycle where note_valid and
//   note_ready are both high; the master holds the command stable until then.
//
//   Signals:
//     note_valid   master -> slave  command valid
//     note_ready   slave  -> master command can be accepted this cycle
//     note_player  master -> slave  target player index
//     note_on      master -> slave  1 = start/retrigger, 0 = stop
//     note_ftw     master -> slave  tuning word (used only when note_on = 1)
// -----------------------------------------------------------------------------
interface dds_phase_acc_if
    import dds_pkg::*;
#(
    parameter int PID_WIDTH = DDS_PID_WIDTH,
    parameter int FTW_WIDTH = DDS_FTW_WIDTH
);

    logic                 note_valid;
    logic                 note_ready;
    logic [PID_WIDTH-1:0] note_player;
    logic                 note_on;
    logic [FTW_WIDTH-1:0] note_ftw;

    modport master (
        output note_valid,
        output note_player,
        output note_on,
        output note_ftw,
        input  note_ready
    );

    modport slave (
        input  note_valid,
        input  note_player,
        input  note_on,
        input  note_ftw,
        output note_ready
    );

endinterface

// File: rtl/dds_phase_acc_sample_tick_gen.sv
// -----------------------------------------------------------------------------
// sample_tick_gen
//   Free-running sample-rate divider. Counts 0..SAMPLE_DIV-1 and wraps.
//
//   Ports:
//     clk            in   system clock
//     rst_n          in   asynchronous active-low reset
//     sample_tick_o  out  registered one-cycle pulse, high in the cycle after
//                         the divider sits at SAMPLE_DIV-1
//     blocked_o      out  high while the divider sits at SAMPLE_DIV-1; this is
//                         the accumulate cycle, during which commands stall
// -----------------------------------------------------------------------------
module sample_tick_gen #(
    parameter int SAMPLE_DIV = 1024
) (
    input  logic clk,
    input  logic rst_n,
    output logic sample_tick_o,
    output logic blocked_o
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic             at_last;

    assign at_last = (div_q == DIV_LAST);

    always_comb begin
        div_d  = at_last ? '0 : div_q + 1'b1;
        // The pulse lands exactly when the accumulators show their new value.
        tick_d = at_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign sample_tick_o = tick_q;
    assign blocked_o     = at_last;

endmodule

// File: rtl/dds_phase_acc.sv
// -----------------------------------------------------------------------------
// dds_phase_acc
//   Per-player phase accumulator feeding the DDS waveform lookup stage.
//   Each player owns a tuning word and an accumulator. On every sample tick
//   each active accumulator advances by its zero-extended tuning word
//   (modulo 2^ACC_WIDTH); the top THETA_WIDTH bits are that player's theta.
//
//   Ports:
//     clk            in   system clock
//     rst_n          in   asynchronous active-low reset
//     note_if        slave note-command handshake (valid/ready/player/on/ftw)
//     sample_tick_o  out  one-cycle pulse; theta_o shows the updated phase
//     active_o       out  bit i = player i sounding
//     theta_o        out  player i phase at [THETA_WIDTH*i +: THETA_WIDTH]
//
//   Commands are refused only in the accumulate cycle, so a command and an
//   accumulation never touch the same player state in one cycle. A command
//   addressed to a nonexistent player completes the handshake and is ignored.
// -----------------------------------------------------------------------------
module dds_phase_acc
    import dds_pkg::*;
#(
    parameter int PLAYER_NUM  = DDS_PLAYER_NUM,
    parameter int THETA_WIDTH = DDS_THETA_WIDTH,
    parameter int ACC_WIDTH   = DDS_ACC_WIDTH,   // must be >= THETA_WIDTH
    parameter int FTW_WIDTH   = DDS_FTW_WIDTH,   // must be <= ACC_WIDTH
    parameter int SAMPLE_DIV  = 1024,            // must be >= 2
    parameter int PID_WIDTH   = pid_width(PLAYER_NUM)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    dds_phase_acc_if.slave                    note_if,
    output logic                              sample_tick_o,
    output logic [PLAYER_NUM-1:0]             active_o,
    output logic [PLAYER_NUM*THETA_WIDTH-1:0] theta_o
);

    logic blocked;
    logic cmd_fire;

    sample_tick_gen #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_tick (
        .clk           (clk),
        .rst_n         (rst_n),
        .sample_tick_o (sample_tick_o),
        .blocked_o     (blocked)
    );

    // Ready is purely a function of the divider, never of note_valid.
    assign note_if.note_ready = ~blocked;
    assign cmd_fire           = note_if.note_valid & ~blocked;

    for (genvar i = 0; i < PLAYER_NUM; i++) begin : g_player
        logic [ACC_WIDTH-1:0] acc_q, acc_d;
        logic [FTW_WIDTH-1:0] ftw_q, ftw_d;
        logic                 active_q, active_d;
        logic                 hit;

        // Out-of-range indices never match any player, so they fall through.
        assign hit = cmd_fire && (note_if.note_player == PID_WIDTH'(i));

        always_comb begin
            acc_d    = acc_q;
            ftw_d    = ftw_q;
            active_d = active_q;
            if (hit) begin
                // Start, retrigger and stop all restart phase from zero;
                // a stop keeps the last tuning word.
                acc_d    = '0;
                active_d = note_if.note_on;
                if (note_if.note_on) begin
                    ftw_d = note_if.note_ftw;
                end
            end else if (blocked && active_q) begin
                acc_d = acc_q + ACC_WIDTH'(ftw_q);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc_q    <= '0;
                ftw_q    <= '0;
                active_q <= 1'b0;
            end else begin
                acc_q    <= acc_d;
                ftw_q    <= ftw_d;
                active_q <= active_d;
            end
        end

        assign active_o[i]                          = active_q;
        assign theta_o[THETA_WIDTH*i +: THETA_WIDTH] = acc_q[ACC_WIDTH-1 -: THETA_WIDTH];
    end

endmodule

// File: tb/tb_dds_phase_acc.sv
module tb_dds_phase_acc;
    import dds_pkg::*;

    localparam int PN   = 3;
    localparam int TW   = 8;
    localparam int AW   = 16;
    localparam int FW   = 16;
    localparam int SDIV = 4;
    localparam int PW   = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sample_tick;
    logic [PN-1:0] active;
    logic [PN*TW-1:0] theta;

    int n_chk = 0;
    int n_err = 0;

    dds_phase_acc_if #(.PID_WIDTH(PW), .FTW_WIDTH(FW)) nif ();

    dds_phase_acc #(
        .PLAYER_NUM  (PN),
        .THETA_WIDTH (TW),
        .ACC_WIDTH   (AW),
        .FTW_WIDTH   (FW),
        .SAMPLE_DIV  (SDIV),
        .PID_WIDTH   (PW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .note_if       (nif),
        .sample_tick_o (sample_tick),
        .active_o      (active),
        .theta_o       (theta)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [TW-1:0] th(input int p);
        return theta[TW*p +: TW];
    endfunction

    // Advance one clock; inputs driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic to_tick();
        bit seen = 0;
        for (int t = 0; t < 2*SDIV; t++) begin
            step();
            if (sample_tick) begin
                seen = 1;
                break;
            end
        end
        chk("tick_timeout", 32'(seen), 32'd1);
    endtask

    task automatic send(input note_cmd_t c);
        bit done = 0;
        bit rdy;
        nif.note_player = c.player;
        nif.note_on     = c.on;
        nif.note_ftw    = c.ftw;
        nif.note_valid  = 1'b1;
        for (int t = 0; t < 2*SDIV; t++) begin
            rdy = nif.note_ready;
            step();
            if (rdy) begin
                done = 1;
                break;
            end
        end
        nif.note_valid = 1'b0;
        chk("send_accept", 32'(done), 32'd1);
    endtask

    initial begin
        rst_n           = 1'b0;
        nif.note_valid  = 1'b0;
        nif.note_player = '0;
        nif.note_on     = 1'b0;
        nif.note_ftw    = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tick",   32'(sample_tick), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_theta",  32'(theta), 32'd0);
        chk("rst_ready",  32'(nif.note_ready), 32'd1);
        rst_n = 1'b1;

        // Idle: pulse every 4 cycles, ready low only before each pulse
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("idle_tick",   32'(sample_tick), 32'((k % SDIV) == 0));
            chk("idle_ready",  32'(nif.note_ready), 32'((k % SDIV) != SDIV-1));
            chk("idle_active", 32'(active), 32'd0);
            chk("idle_theta",  32'(theta), 32'd0);
        end

        // Player 1, ftw 0x0100: theta steps by 1 per tick, wraps after 256
        send('{player: 2'd1, on: 1'b1, ftw: 16'h0100});
        chk("p1_on_active", 32'(active), 32'b010);
        chk("p1_on_theta",  32'(theta), 32'd0);
        for (int n = 1; n <= 256; n++) begin
            to_tick();
            chk("p1_step", 32'(th(1)), 32'(n % 256));
        end
        chk("p1_wrap_th0", 32'(th(0)), 32'd0);
        chk("p1_wrap_th2", 32'(th(2)), 32'd0);

        // Player 2, ftw 0xFFFF: acc FFFF, FFFE, FFFD -> theta stays FF
        send('{player: 2'd2, on: 1'b1, ftw: 16'hFFFF});
        chk("p2_on_active", 32'(active), 32'b110);
        for (int n = 1; n <= 3; n++) begin
            to_tick();
            chk("p2_ffff", 32'(th(2)), 32'hFF);
        end
        chk("p1_after_wrap", 32'(th(1)), 32'd3);

        // Player 0 start, then retrigger mid-note with ftw 0x0200
        send('{player: 2'd0, on: 1'b1, ftw: 16'h0100});
        to_tick();
        chk("p0_first", 32'(th(0)), 32'd1);
        chk("p1_cont",  32'(th(1)), 32'd4);
        send('{player: 2'd0, on: 1'b1, ftw: 16'h0200});
        chk("p0_retrig_zero", 32'(th(0)), 32'd0);
        chk("p0_retrig_act",  32'(active), 32'b111);
        to_tick();
        chk("p0_by2_a", 32'(th(0)), 32'd2);
        to_tick();
        chk("p0_by2_b", 32'(th(0)), 32'd4);

        // Command held across the blocked cycle
        repeat (3) step();
        chk("blk_ready", 32'(nif.note_ready), 32'd0);
        nif.note_player = 2'd0;
        nif.note_on     = 1'b1;
        nif.note_ftw    = 16'h0300;
        nif.note_valid  = 1'b1;
        step();
        chk("blk_tick",  32'(sample_tick), 32'd1);
        chk("blk_old",   32'(th(0)), 32'd6);
        chk("blk_ready2", 32'(nif.note_ready), 32'd1);
        step();
        nif.note_valid = 1'b0;
        chk("blk_late_accept", 32'(th(0)), 32'd0);
        to_tick();
        chk("blk_new_ftw", 32'(th(0)), 32'd3);

        // Nonexistent player: handshake completes, nothing changes
        send('{player: 2'd3, on: 1'b1, ftw: 16'h1234});
        chk("badp_active", 32'(active), 32'b111);
        chk("badp_theta0", 32'(th(0)), 32'd3);

        // Stop player 1, then stop it again
        send('{player: 2'd1, on: 1'b0, ftw: 16'h0000});
        chk("off_active", 32'(active), 32'b101);
        chk("off_theta1", 32'(th(1)), 32'd0);
        send('{player: 2'd1, on: 1'b0, ftw: 16'h0000});
        chk("off2_active", 32'(active), 32'b101);

        // FTW = 0 while active: theta stays 0, player stays active
        send('{player: 2'd1, on: 1'b1, ftw: 16'h0000});
        to_tick();
        chk("ftw0_theta1", 32'(th(1)), 32'd0);
        chk("ftw0_active", 32'(active), 32'b111);

        // Asynchronous reset mid-note with a command in flight
        nif.note_player = 2'd1;
        nif.note_on     = 1'b1;
        nif.note_ftw    = 16'h5000;
        nif.note_valid  = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_active", 32'(active), 32'd0);
        chk("arst_theta",  32'(theta), 32'd0);
        chk("arst_tick",   32'(sample_tick), 32'd0);
        step();
        nif.note_valid = 1'b0;
        chk("arst_hold_active", 32'(active), 32'd0);
        rst_n = 1'b1;
        step();
        chk("arst_rel_ready",  32'(nif.note_ready), 32'd1);
        chk("arst_rel_active", 32'(active), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
